ped_signal: RTL and testbench
=============================

PED_SIGNAL -- requirements
Module: ped_signal

Interface
REQ-001 Parameter WALK_TIMES, 3, WALK phase length in clocks (1..15).
REQ-002 Parameter FLASH_TIMES, 2, FLASH phase length in clocks (1..15).
REQ-003 Parameter LIGHT_G, 3'b001, vehicle green code.
REQ-004 Parameter LIGHT_Y, 3'b010, vehicle yellow code.
REQ-005 Parameter LIGHT_R, 3'b100, vehicle red code.
REQ-006 Port clk  input  1  single clock; all state updates on rising edge.
REQ-007 Port rst_p  input  1  reset; asynchronous, active-high.
REQ-008 Port light  input  3  one-hot vehicle light from the upstream traffic controller.
REQ-009 Port ped_btn  input  1  pedestrian request, level sampled each clock.
REQ-010 Port walk  output  1  pedestrian WALK lamp.
REQ-011 Port dont_walk  output  1  pedestrian DON'T-WALK lamp.
REQ-012 Port req_pending  output  1  request latched, not yet served.
REQ-013 Port remain  output  4  clocks left in the current WALK or FLASH phase, including the current clock.
REQ-014 Port fault  output  1  sticky illegal-light flag.

Function
REQ-015 States SHALL be IDLE, ARMED, WALK, FLASH, plus a phase counter cnt[3:0] and a registered prev_red.
REQ-016 is_red SHALL be 1 iff light==LIGHT_R and fault==0; red_rise SHALL be is_red & ~prev_red; prev_red <= is_red every clock.
REQ-017 IDLE: ped_btn=1 -> ARMED; else stay. ped_btn and red_rise together in IDLE -> ARMED only (no same-cycle grant).
REQ-018 ARMED: red_rise=1 -> WALK with cnt<=0; else stay.
REQ-019 WALK: cnt increments; at cnt==WALK_TIMES-1 -> FLASH with cnt<=0; WALK lasts exactly WALK_TIMES clocks.
REQ-020 FLASH: cnt increments; at cnt==FLASH_TIMES-1 -> ARMED if pend_next==1, else IDLE; cnt<=0.
REQ-021 pend_next SHALL be set by ped_btn=1 in any WALK/FLASH clock and cleared on leaving FLASH or on abort.
REQ-022 Abort: in WALK or FLASH, is_red==0 -> next state ARMED if pend_next or ped_btn, else IDLE; cnt<=0.
REQ-023 walk SHALL be 1 in WALK, and count bit cnt[0] in FLASH, both gated by is_red (combinational, so a red loss blanks walk in the same clock); 0 otherwise.
REQ-024 dont_walk SHALL equal ~walk in IDLE/ARMED/abort; in WALK/FLASH it SHALL be ~is_red; walk and dont_walk SHALL never both be 1.
REQ-025 req_pending SHALL be 1 in ARMED, or in WALK/FLASH when pend_next==1; 0 otherwise.
REQ-026 remain SHALL be WALK_TIMES-cnt in WALK, FLASH_TIMES-cnt in FLASH, 0 in IDLE/ARMED.
REQ-027 fault SHALL set on any clock where light is not one of LIGHT_G/LIGHT_Y/LIGHT_R; it clears only on reset; while fault=1 the block SHALL stay in or return to IDLE/ARMED (never grant).

Reset
REQ-028 rst_p=1 SHALL immediately force state IDLE, cnt=0, pend_next=0, fault=0, prev_red=1.
REQ-029 During/after reset outputs SHALL read walk=0, dont_walk=1, req_pending=0, remain=0, fault=0.
REQ-030 prev_red resetting to 1 SHALL prevent a red already present at reset release from counting as red_rise.
REQ-031 Reset asserted mid-WALK or mid-FLASH SHALL abandon the phase and drop any pending request.

Verification
REQ-032 Reset, light=R held, ped_btn pulse 1 clock -> ARMED, req_pending=1, no walk until light goes G then back to R.
REQ-033 ARMED, light G->R edge -> walk=1 for 3 clocks with remain 3,2,1; then FLASH walk 0,1 with remain 2,1; then dont_walk=1, IDLE.
REQ-034 ped_btn pressed during WALK -> req_pending stays 1; after FLASH ends state=ARMED; next red edge grants again.
REQ-035 Light changes R->G at WALK cnt=1 -> walk=0 and dont_walk=1 in that same clock; state IDLE next clock.
REQ-036 light=3'b011 for one clock -> fault=1 held; later valid red edges with ped_btn never assert walk until rst_p.
REQ-037 ped_btn=1 coincident with red_rise in IDLE -> ARMED, no walk this red; walk on the following red edge.

Source files
------------

// File: rtl/ped_signal.sv
`default_nettype none
// ============================================================================
// Module      : ped_signal
// Description : Pedestrian crossing lamp controller slaved to an upstream
//               vehicle traffic light. A button press arms a request; the
//               next rising edge of vehicle red grants a WALK phase followed
//               by a flashing phase. Loss of red aborts the phase at once,
//               and an illegal light code latches a sticky fault that
//               inhibits every further grant until reset.
// Ports       : clk         - clock, rising edge active
//               rst_p       - asynchronous active-high reset
//               light[2:0]  - one-hot vehicle light (G/Y/R codes)
//               ped_btn     - pedestrian request level
//               walk        - WALK lamp
//               dont_walk   - DON'T-WALK lamp
//               req_pending - request latched, not yet served
//               remain[3:0] - clocks left in WALK/FLASH, current included
//               fault       - sticky illegal-light flag
// Revision    : 1.0 - initial release
// ============================================================================
module ped_signal #(
  parameter int       WALK_TIMES  = 3,
  parameter int       FLASH_TIMES = 2,
  parameter bit [2:0] LIGHT_G     = 3'b001,
  parameter bit [2:0] LIGHT_Y     = 3'b010,
  parameter bit [2:0] LIGHT_R     = 3'b100
) (
  input  logic       clk,
  input  logic       rst_p,
  input  logic [2:0] light,
  input  logic       ped_btn,
  output logic       walk,
  output logic       dont_walk,
  output logic       req_pending,
  output logic [3:0] remain,
  output logic       fault
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARMED = 2'd1,
    S_WALK  = 2'd2,
    S_FLASH = 2'd3
  } state_t;

  localparam logic [3:0] c_WALK_LEN  = 4'(WALK_TIMES);
  localparam logic [3:0] c_FLASH_LEN = 4'(FLASH_TIMES);
  localparam logic [3:0] c_WALK_LAST  = 4'(WALK_TIMES - 1);
  localparam logic [3:0] c_FLASH_LAST = 4'(FLASH_TIMES - 1);

  state_t     r_state;
  logic [3:0] r_cnt;
  logic       r_pend;
  logic       r_fault;
  logic       r_prev_red;

  logic       w_is_red;
  logic       w_red_rise;
  logic       w_illegal;
  logic       w_in_phase;

  // A latched fault masks red entirely, so no red edge can ever be seen
  // and any running phase aborts on the next clock.
  assign w_is_red   = (light == LIGHT_R) && !r_fault;
  assign w_red_rise = w_is_red && !r_prev_red;
  assign w_illegal  = (light != LIGHT_G) && (light != LIGHT_Y) && (light != LIGHT_R);
  assign w_in_phase = (r_state == S_WALK) || (r_state == S_FLASH);

  always_ff @(posedge clk or posedge rst_p) begin
    if (rst_p) begin
      r_state    <= S_IDLE;
      r_cnt      <= 4'd0;
      r_pend     <= 1'b0;
      r_fault    <= 1'b0;
      // Starting high keeps a red already present at reset release from
      // looking like a fresh red edge.
      r_prev_red <= 1'b1;
    end else begin
      r_prev_red <= w_is_red;
      if (w_illegal) begin
        r_fault <= 1'b1;
      end
      case (r_state)
        S_IDLE: begin
          // A press coincident with a red edge only arms; the grant waits
          // for the following red edge.
          if (ped_btn) begin
            r_state <= S_ARMED;
          end
        end
        S_ARMED: begin
          if (w_red_rise) begin
            r_state <= S_WALK;
            r_cnt   <= 4'd0;
          end
        end
        S_WALK, S_FLASH: begin
          if (!w_is_red) begin
            r_state <= (r_pend || ped_btn) ? S_ARMED : S_IDLE;
            r_cnt   <= 4'd0;
            r_pend  <= 1'b0;
          end else if (r_state == S_WALK) begin
            if (ped_btn) begin
              r_pend <= 1'b1;
            end
            if (r_cnt == c_WALK_LAST) begin
              r_state <= S_FLASH;
              r_cnt   <= 4'd0;
            end else begin
              r_cnt <= r_cnt + 4'd1;
            end
          end else begin
            if (r_cnt == c_FLASH_LAST) begin
              // A press in the final flash clock still re-arms.
              r_state <= (r_pend || ped_btn) ? S_ARMED : S_IDLE;
              r_cnt   <= 4'd0;
              r_pend  <= 1'b0;
            end else begin
              if (ped_btn) begin
                r_pend <= 1'b1;
              end
              r_cnt <= r_cnt + 4'd1;
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_cnt   <= 4'd0;
          r_pend  <= 1'b0;
        end
      endcase
    end
  end

  // Lamps are gated by the live red so a red loss blanks WALK in the same
  // clock rather than one clock later.
  always_comb begin
    walk = 1'b0;
    if (w_is_red) begin
      if (r_state == S_WALK) begin
        walk = 1'b1;
      end else if (r_state == S_FLASH) begin
        walk = r_cnt[0];
      end
    end
  end

  // During FLASH with cnt[0]==0 both lamps are dark (the flash off beat).
  assign dont_walk   = w_in_phase ? !w_is_red : !walk;
  assign req_pending = (r_state == S_ARMED) || (w_in_phase && r_pend);
  assign fault       = r_fault;

  always_comb begin
    remain = 4'd0;
    if (r_state == S_WALK) begin
      remain = c_WALK_LEN - r_cnt;
    end else if (r_state == S_FLASH) begin
      remain = c_FLASH_LEN - r_cnt;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ped_signal.sv
`default_nettype none
// ============================================================================
// Module      : tb_ped_signal
// Description : Directed self-checking bench for ped_signal. Each step drives
//               light/ped_btn on the falling edge, pushes the hand-derived
//               expected lamp outputs to a scoreboard, then pops and compares
//               them against the DUT shortly after.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ped_signal;

  localparam logic [2:0] c_G = 3'b001;
  localparam logic [2:0] c_Y = 3'b010;
  localparam logic [2:0] c_R = 3'b100;

  logic       clk = 1'b0;
  logic       rst_p = 1'b1;
  logic [2:0] light = c_R;
  logic       ped_btn = 1'b0;
  logic       walk;
  logic       dont_walk;
  logic       req_pending;
  logic [3:0] remain;
  logic       fault;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string      tag;
    logic       w;
    logic       dw;
    logic       rp;
    logic [3:0] rem;
    logic       f;
  } exp_t;

  exp_t sb[$];

  ped_signal #(
    .WALK_TIMES  (3),
    .FLASH_TIMES (2),
    .LIGHT_G     (3'b001),
    .LIGHT_Y     (3'b010),
    .LIGHT_R     (3'b100)
  ) dut (
    .clk         (clk),
    .rst_p       (rst_p),
    .light       (light),
    .ped_btn     (ped_btn),
    .walk        (walk),
    .dont_walk   (dont_walk),
    .req_pending (req_pending),
    .remain      (remain),
    .fault       (fault)
  );

  always #5 clk = ~clk;

  task automatic push_exp(input string tag, input logic w, input logic dw,
                          input logic rp, input logic [3:0] rem, input logic f);
    exp_t e;
    e.tag = tag; e.w = w; e.dw = dw; e.rp = rp; e.rem = rem; e.f = f;
    sb.push_back(e);
  endtask

  task automatic check_out();
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL scoreboard empty: observed none required entry");
      return;
    end
    e = sb.pop_front();
    checks++;
    assert (walk === e.w) else begin
      errors++;
      $error("FAIL %s walk: observed %b expected %b", e.tag, walk, e.w);
    end
    checks++;
    assert (dont_walk === e.dw) else begin
      errors++;
      $error("FAIL %s dont_walk: observed %b expected %b", e.tag, dont_walk, e.dw);
    end
    checks++;
    assert (req_pending === e.rp) else begin
      errors++;
      $error("FAIL %s req_pending: observed %b expected %b", e.tag, req_pending, e.rp);
    end
    checks++;
    assert (remain === e.rem) else begin
      errors++;
      $error("FAIL %s remain: observed %0d expected %0d", e.tag, remain, e.rem);
    end
    checks++;
    assert (fault === e.f) else begin
      errors++;
      $error("FAIL %s fault: observed %b expected %b", e.tag, fault, e.f);
    end
    checks++;
    assert (!(walk === 1'b1 && dont_walk === 1'b1)) else begin
      errors++;
      $error("FAIL %s lamp_overlap: observed walk=%b dont_walk=%b expected not both 1",
             e.tag, walk, dont_walk);
    end
  endtask

  // One clock of stimulus: drive on the falling edge, check 1ns later,
  // then the following rising edge applies it.
  task automatic step(input string tag, input logic [2:0] l, input logic b,
                      input logic w, input logic dw, input logic rp,
                      input logic [3:0] rem, input logic f);
    @(negedge clk);
    light   = l;
    ped_btn = b;
    push_exp(tag, w, dw, rp, rem, f);
    #1;
    check_out();
  endtask

  // Asserts reset with the given light, checks outputs immediately and after
  // a rising edge, then releases on a falling edge.
  task automatic do_reset(input string tag, input logic [2:0] l);
    @(negedge clk);
    light   = l;
    ped_btn = 1'b0;
    rst_p   = 1'b1;
    push_exp(tag, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0);
    #1;
    check_out();
    @(posedge clk);
    #1;
    push_exp(tag, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0);
    check_out();
    @(negedge clk);
    rst_p = 1'b0;
  endtask

  initial begin
    do_reset("rst0", c_R);

    // Red held through reset: a press arms but nothing is granted.
    step("A1_idle",     c_R, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0);
    step("A2_press",    c_R, 1'b1, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0);
    step("A3_armed",    c_R, 1'b0, 1'b0, 1'b1, 1'b1, 4'd0, 1'b0);
    step("A4_armed",    c_R, 1'b0, 1'b0, 1'b1, 1'b1, 4'd0, 1'b0);
    step("A5_green",    c_G, 1'b0, 1'b0, 1'b1, 1'b1, 4'd0, 1'b0);
    step("A6_redrise",  c_R, 1'b0, 1'b0, 1'b1, 1'b1, 4'd0, 1'b0);
    // Full WALK then FLASH.
    step("B1_walk3",    c_R, 1'b0, 1'b1, 1'b0, 1'b0, 4'd3, 1'b0);
    step("B2_walk2",    c_R, 1'b0, 1'b1, 1'b0, 1'b0, 4'd2, 1'b0);
    step("B3_walk1",    c_R, 1'b0, 1'b1, 1'b0, 1'b0, 4'd1, 1'b0);
    step("B4_flash2",   c_R, 1'b0, 1'b0, 1'b0, 1'b0, 4'd2, 1'b0);
    step("B5_flash1",   c_R, 1'b0, 1'b1, 1'b0, 1'b0, 4'd1, 1'b0);
    step("B6_idle",     c_R, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0);
    // Press during WALK re-arms after FLASH.
    step("C1_press",    c_R, 1'b1, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0);
    step("C2_green",    c_G, 1'b0, 1'b0, 1'b1, 1'b1, 4'd0, 1'b0);
    step("C3_redrise",  c_R, 1'b0, 1'b0, 1'b1, 1'b1, 4'd0, 1'b0);
    step("C4_walkpress",c_R, 1'b1, 1'b1, 1'b0, 1'b0, 4'd3, 1'b0);
    step("C5_walk2",    c_R, 1'b0, 1'b1, 1'b0, 1'b1, 4'd2, 1'b0);
    step("C6_walk1",    c_R, 1'b0, 1'b1, 1'b0, 1'b1, 4'd1, 1'b0);
    step("C7_flash2",   c_R, 1'b0, 1'b0, 1'b0, 1'b1, 4'd2, 1'b0);
    step("C8_flash1",   c_R, 1'b0, 1'b1, 1'b0, 1'b1, 4'd1, 1'b0);
    step("C9_rearmed",  c_R, 1'b0, 1'b0, 1'b1, 1'b1, 4'd0, 1'b0);
    step("C10_green",   c_G, 1'b0, 1'b0, 1'b1, 1'b1, 4'd0, 1'b0);
    step("C11_redrise", c_R, 1'b0, 1'b0, 1'b1, 1'b1, 4'd0, 1'b0);
    step("C12_walk3",   c_R, 1'b0, 1'b1, 1'b0, 1'b0, 4'd3, 1'b0);
    // Red lost at WALK cnt=1: lamps blank in the same clock.
    step("D1_abort",    c_G, 1'b0, 1'b0, 1'b1, 1'b0, 4'd2, 1'b0);
    step("D2_idle",     c_G, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0);
    // Press coincident with red edge only arms.
    step("E1_pressrise",c_R, 1'b1, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0);
    step("E2_nogrant",  c_R, 1'b0, 1'b0, 1'b1, 1'b1, 4'd0, 1'b0);
    step("E3_green",    c_G, 1'b0, 1'b0, 1'b1, 1'b1, 4'd0, 1'b0);
    step("E4_redrise",  c_R, 1'b0, 1'b0, 1'b1, 1'b1, 4'd0, 1'b0);
    step("E5_walk3",    c_R, 1'b0, 1'b1, 1'b0, 1'b0, 4'd3, 1'b0);
    // Abort with a pending request returns to ARMED and re-grants.
    step("E6_walkpress",c_R, 1'b1, 1'b1, 1'b0, 1'b0, 4'd2, 1'b0);
    step("E7_yabort",   c_Y, 1'b0, 1'b0, 1'b1, 1'b1, 4'd1, 1'b0);
    step("E8_regrant",  c_R, 1'b0, 1'b0, 1'b1, 1'b1, 4'd0, 1'b0);
    step("E9_walk3",    c_R, 1'b0, 1'b1, 1'b0, 1'b0, 4'd3, 1'b0);
    // Illegal light: abort, sticky fault, no further grants.
    step("F1_illegal",  3'b011, 1'b0, 1'b0, 1'b1, 1'b0, 4'd2, 1'b0);
    step("F2_fault",    c_G, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 1'b1);
    step("F3_press",    c_R, 1'b1, 1'b0, 1'b1, 1'b0, 4'd0, 1'b1);
    step("F4_green",    c_G, 1'b0, 1'b0, 1'b1, 1'b1, 4'd0, 1'b1);
    step("F5_red",      c_R, 1'b0, 1'b0, 1'b1, 1'b1, 4'd0, 1'b1);
    step("F6_red",      c_R, 1'b1, 1'b0, 1'b1, 1'b1, 4'd0, 1'b1);

    do_reset("rst1", c_R);

    // Reset mid-WALK drops the phase and the pending request.
    step("G1_press",    c_R, 1'b1, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0);
    step("G2_green",    c_G, 1'b0, 1'b0, 1'b1, 1'b1, 4'd0, 1'b0);
    step("G3_redrise",  c_R, 1'b0, 1'b0, 1'b1, 1'b1, 4'd0, 1'b0);
    step("G4_walkpress",c_R, 1'b1, 1'b1, 1'b0, 1'b0, 4'd3, 1'b0);
    step("G5_walk2",    c_R, 1'b0, 1'b1, 1'b0, 1'b1, 4'd2, 1'b0);

    do_reset("rst2", c_R);

    step("G6_idle",     c_R, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0);
    step("G7_green",    c_G, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0);
    step("G8_redrise",  c_R, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0);
    step("G9_idle",     c_R, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0);

    checks++;
    assert (sb.size() == 0) else begin
      errors++;
      $error("FAIL scoreboard_drain: observed %0d entries expected 0", sb.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
